// File: rtl/sa_tile_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sa_tile_sequencer_pkg
// Description : Shared state encoding and sizing constants for the tile
//               sequencer around the 4x4 systolic array.
// Revision    : 1.0 - initial release
// ============================================================================
package sa_tile_sequencer_pkg;

    localparam int c_rows            = 4;
    localparam int c_timeout_default = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_STORE = 3'd3,
        S_NEXT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    // Offset of the first row of a tile inside a global buffer.
    function automatic logic [31:0] tile_offset(input logic [7:0] tile);
        return {22'd0, tile, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_result_capture.sv
`default_nettype none
// ============================================================================
// Module      : sa_result_capture
// Description : 4-row result capture register with a row-select read port.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_result_capture
    import sa_tile_sequencer_pkg::*;
#(
    parameter int DATAC_BITS = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATAC_BITS-1:0] i_row0,
    input  logic [DATAC_BITS-1:0] i_row1,
    input  logic [DATAC_BITS-1:0] i_row2,
    input  logic [DATAC_BITS-1:0] i_row3,
    input  logic [1:0]            i_sel,
    output logic [DATAC_BITS-1:0] o_row
);

    logic [DATAC_BITS-1:0] r_rows [c_rows];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_rows; i++) begin
                r_rows[i] <= '0;
            end
        end else if (i_load) begin
            r_rows[0] <= i_row0;
            r_rows[1] <= i_row1;
            r_rows[2] <= i_row2;
            r_rows[3] <= i_row3;
        end
    end

    assign o_row = r_rows[i_sel];

endmodule
`default_nettype wire

// File: rtl/sa_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sa_tile_sequencer
// Description : Streams A/B tiles into the 4x4 systolic array, runs it and
//               writes the four result rows back to global buffer C.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_tile_sequencer
    import sa_tile_sequencer_pkg::*;
#(
    parameter int ADDR_BITS   = 16,
    parameter int DATA_BITS   = 32,
    parameter int DATAC_BITS  = 128,
    parameter int TIMEOUT_CYC = c_timeout_default
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            tile_count,
    input  logic [ADDR_BITS-1:0]  a_base,
    input  logic [ADDR_BITS-1:0]  b_base,
    input  logic [ADDR_BITS-1:0]  c_base,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_BITS-1:0]  A_index,
    output logic [ADDR_BITS-1:0]  B_index,
    input  logic [DATA_BITS-1:0]  A_data_out,
    input  logic [DATA_BITS-1:0]  B_data_out,
    output logic                  C_wr_en,
    output logic [ADDR_BITS-1:0]  C_index,
    output logic [DATAC_BITS-1:0] C_data_in,
    output logic                  sa_rst_n,
    output logic [DATA_BITS-1:0]  local_buffer_A0,
    output logic [DATA_BITS-1:0]  local_buffer_A1,
    output logic [DATA_BITS-1:0]  local_buffer_A2,
    output logic [DATA_BITS-1:0]  local_buffer_A3,
    output logic [DATA_BITS-1:0]  local_buffer_B0,
    output logic [DATA_BITS-1:0]  local_buffer_B1,
    output logic [DATA_BITS-1:0]  local_buffer_B2,
    output logic [DATA_BITS-1:0]  local_buffer_B3,
    input  logic [DATAC_BITS-1:0] local_buffer_C0,
    input  logic [DATAC_BITS-1:0] local_buffer_C1,
    input  logic [DATAC_BITS-1:0] local_buffer_C2,
    input  logic [DATAC_BITS-1:0] local_buffer_C3,
    input  logic                  sa_done
);

    localparam int                c_cnt_w    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);
    localparam logic [2:0]        c_step_last = 3'(c_rows - 1);
    localparam logic [2:0]        c_load_last = 3'(c_rows);

    state_t                r_state;
    logic [7:0]            r_tile;
    logic [7:0]            r_tiles;
    logic [ADDR_BITS-1:0]  r_a_base;
    logic [ADDR_BITS-1:0]  r_b_base;
    logic [ADDR_BITS-1:0]  r_c_base;
    logic [2:0]            r_step;
    logic [c_cnt_w-1:0]    r_run_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  r_sa_rst_n;
    logic                  r_wr_en;
    logic [ADDR_BITS-1:0]  r_a_idx;
    logic [ADDR_BITS-1:0]  r_b_idx;
    logic [ADDR_BITS-1:0]  r_c_idx;
    logic [DATA_BITS-1:0]  r_op_a [c_rows];
    logic [DATA_BITS-1:0]  r_op_b [c_rows];

    logic                  w_capture;
    logic [1:0]            w_op_slot;

    assign w_capture = (r_state == S_RUN) && sa_done;
    // LOAD step k captures the word addressed in step k-1.
    assign w_op_slot = r_step[1:0] - 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tile     <= '0;
            r_tiles    <= '0;
            r_a_base   <= '0;
            r_b_base   <= '0;
            r_c_base   <= '0;
            r_step     <= '0;
            r_run_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_sa_rst_n <= 1'b0;
            r_wr_en    <= 1'b0;
            r_a_idx    <= '0;
            r_b_idx    <= '0;
            r_c_idx    <= '0;
            for (int i = 0; i < c_rows; i++) begin
                r_op_a[i] <= '0;
                r_op_b[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_tiles  <= tile_count;
                        r_a_base <= a_base;
                        r_b_base <= b_base;
                        r_c_base <= c_base;
                        r_error  <= 1'b0;
                        r_tile   <= '0;
                        r_busy   <= 1'b1;
                        if (tile_count == 8'd0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_step  <= '0;
                            r_a_idx <= a_base;
                            r_b_idx <= b_base;
                        end
                    end
                end
                S_LOAD: begin
                    if (r_step != 3'd0) begin
                        r_op_a[w_op_slot] <= A_data_out;
                        r_op_b[w_op_slot] <= B_data_out;
                    end
                    if (r_step == c_load_last) begin
                        r_state    <= S_RUN;
                        r_sa_rst_n <= 1'b1;
                        r_run_cnt  <= '0;
                    end else begin
                        r_step <= r_step + 3'd1;
                        if (r_step < c_step_last) begin
                            r_a_idx <= r_a_idx + ADDR_BITS'(1);
                            r_b_idx <= r_b_idx + ADDR_BITS'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (sa_done) begin
                        r_sa_rst_n <= 1'b0;
                        r_state    <= S_STORE;
                        r_step     <= '0;
                        r_wr_en    <= 1'b1;
                        r_c_idx    <= r_c_base + ADDR_BITS'(tile_offset(r_tile));
                    end else if (r_run_cnt == c_cnt_last) begin
                        r_sa_rst_n <= 1'b0;
                        r_error    <= 1'b1;
                        r_state    <= S_FIN;
                        r_done     <= 1'b1;
                    end else begin
                        r_run_cnt <= r_run_cnt + c_cnt_w'(1);
                    end
                end
                S_STORE: begin
                    if (r_step == c_step_last) begin
                        r_wr_en <= 1'b0;
                        r_state <= S_NEXT;
                    end else begin
                        r_step  <= r_step + 3'd1;
                        r_c_idx <= r_c_idx + ADDR_BITS'(1);
                    end
                end
                S_NEXT: begin
                    r_tile <= r_tile + 8'd1;
                    if (r_tile + 8'd1 == r_tiles) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_LOAD;
                        r_step  <= '0;
                        r_a_idx <= r_a_base + ADDR_BITS'(tile_offset(r_tile + 8'd1));
                        r_b_idx <= r_b_base + ADDR_BITS'(tile_offset(r_tile + 8'd1));
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    sa_result_capture #(
        .DATAC_BITS (DATAC_BITS)
    ) u_capture (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_capture),
        .i_row0 (local_buffer_C0),
        .i_row1 (local_buffer_C1),
        .i_row2 (local_buffer_C2),
        .i_row3 (local_buffer_C3),
        .i_sel  (r_step[1:0]),
        .o_row  (C_data_in)
    );

    // A write must never reach buffer C while reset is being applied.
    assign C_wr_en         = r_wr_en & ~rst;
    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;
    assign sa_rst_n        = r_sa_rst_n;
    assign A_index         = r_a_idx;
    assign B_index         = r_b_idx;
    assign C_index         = r_c_idx;
    assign local_buffer_A0 = r_op_a[0];
    assign local_buffer_A1 = r_op_a[1];
    assign local_buffer_A2 = r_op_a[2];
    assign local_buffer_A3 = r_op_a[3];
    assign local_buffer_B0 = r_op_b[0];
    assign local_buffer_B1 = r_op_b[1];
    assign local_buffer_B2 = r_op_b[2];
    assign local_buffer_B3 = r_op_b[3];

endmodule
`default_nettype wire

// File: tb/tb_sa_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_tile_sequencer
// Description : Self-checking bench with buffer, array and scoreboard models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_tile_sequencer;

    localparam int c_to = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   tile_count = '0;
    logic [15:0]  a_base = '0, b_base = '0, c_base = '0;
    logic         busy, done, error, C_wr_en, sa_rst_n;
    logic [15:0]  A_index, B_index, C_index;
    logic [31:0]  A_data_out = '0, B_data_out = '0;
    logic [127:0] C_data_in;
    logic [31:0]  lba0, lba1, lba2, lba3, lbb0, lbb1, lbb2, lbb3;
    logic [127:0] lbc0 = '0, lbc1 = '0, lbc2 = '0, lbc3 = '0;
    logic         sa_done = 1'b0;

    logic [31:0]  mem_a [65536];
    logic [31:0]  mem_b [65536];
    logic [15:0]  exp_idx[$], act_idx[$];
    logic [127:0] exp_dat[$], act_dat[$];

    int  checks = 0, errors = 0;
    int  cyc = 0, done_cnt = 0, bad_sarst = 0;
    int  sa_lat = 5, run_cnt = 0;
    bit  sa_dead = 1'b0, sa_spur = 1'b0;

    sa_tile_sequencer dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .tile_count (tile_count),
        .a_base (a_base), .b_base (b_base), .c_base (c_base),
        .busy (busy), .done (done), .error (error),
        .A_index (A_index), .B_index (B_index),
        .A_data_out (A_data_out), .B_data_out (B_data_out),
        .C_wr_en (C_wr_en), .C_index (C_index), .C_data_in (C_data_in),
        .sa_rst_n (sa_rst_n),
        .local_buffer_A0 (lba0), .local_buffer_A1 (lba1),
        .local_buffer_A2 (lba2), .local_buffer_A3 (lba3),
        .local_buffer_B0 (lbb0), .local_buffer_B1 (lbb1),
        .local_buffer_B2 (lbb2), .local_buffer_B3 (lbb3),
        .local_buffer_C0 (lbc0), .local_buffer_C1 (lbc1),
        .local_buffer_C2 (lbc2), .local_buffer_C3 (lbc3),
        .sa_done (sa_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Row i of A x B for packed signed int8 words, element 0 in the MSBs.
    function automatic logic [127:0] mm_row(input logic [31:0] a, input logic [31:0] b0,
                                            input logic [31:0] b1, input logic [31:0] b2,
                                            input logic [31:0] b3);
        logic [31:0]  bw [4];
        logic [127:0] r;
        int           s;
        bw = '{b0, b1, b2, b3};
        r  = '0;
        for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int k = 0; k < 4; k++) begin
                s = s + int'($signed(a[31-8*k -: 8])) * int'($signed(bw[k][31-8*j -: 8]));
            end
            r[127-32*j -: 32] = s;
        end
        return r;
    endfunction

    // Global buffers A/B: data valid one cycle after the index.
    always @(posedge clk) begin
        A_data_out <= mem_a[A_index];
        B_data_out <= mem_b[B_index];
    end

    // Systolic array: pulses sa_done in its sa_lat-th enabled cycle.
    always @(negedge clk) begin
        if (sa_spur) begin
            sa_done = 1'b1;
        end else if (sa_rst_n && !sa_dead) begin
            run_cnt++;
            if (run_cnt == sa_lat) begin
                lbc0 = mm_row(lba0, lbb0, lbb1, lbb2, lbb3);
                lbc1 = mm_row(lba1, lbb0, lbb1, lbb2, lbb3);
                lbc2 = mm_row(lba2, lbb0, lbb1, lbb2, lbb3);
                lbc3 = mm_row(lba3, lbb0, lbb1, lbb2, lbb3);
                sa_done = 1'b1;
            end else begin
                sa_done = 1'b0;
            end
        end else begin
            run_cnt = 0;
            sa_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (C_wr_en) begin
            act_idx.push_back(C_index);
            act_dat.push_back(C_data_in);
        end
        if (done) done_cnt++;
        if (C_wr_en && sa_rst_n) bad_sarst++;
    end

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic build_expected(input int tc, input logic [15:0] ab, input logic [15:0] bb,
                                  input logic [15:0] cb);
        logic [31:0] bw [4];
        exp_idx.delete();
        exp_dat.delete();
        for (int t = 0; t < tc; t++) begin
            for (int k = 0; k < 4; k++) bw[k] = mem_b[16'(bb + 4*t + k)];
            for (int r = 0; r < 4; r++) begin
                exp_idx.push_back(16'(cb + 4*t + r));
                exp_dat.push_back(mm_row(mem_a[16'(ab + 4*t + r)], bw[0], bw[1], bw[2], bw[3]));
            end
        end
    endtask

    task automatic compare_writes(input string tag);
        check_val({tag, " wr count"}, act_idx.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size() && i < act_idx.size(); i++) begin
            check_val($sformatf("%s wr%0d idx", tag, i), act_idx[i], exp_idx[i]);
            check_val($sformatf("%s wr%0d data", tag, i), act_dat[i], exp_dat[i]);
        end
    endtask

    task automatic start_job(input int tc, input logic [15:0] ab, input logic [15:0] bb,
                             input logic [15:0] cb);
        act_idx.delete();
        act_dat.delete();
        done_cnt   = 0;
        in_valid   = 1'b1;
        tile_count = 8'(tc);
        a_base     = ab;
        b_base     = bb;
        c_base     = cb;
        step();
        in_valid   = 1'b0;
        tile_count = 8'($urandom);
        a_base     = 16'($urandom);
        b_base     = 16'($urandom);
        c_base     = 16'($urandom);
    endtask

    task automatic run_job(input int tc, input logic [15:0] ab, input logic [15:0] bb,
                           input logic [15:0] cb, input int lat, input bit dead,
                           input bit poke, input string tag);
        int c0, fin, busy_bad, lat_exp;
        bit seen;
        build_expected(dead ? 0 : tc, ab, bb, cb);
        sa_lat  = lat;
        sa_dead = dead;
        c0 = cyc;
        start_job(tc, ab, bb, cb);
        check_val({tag, " err clr"}, error, 1'b0);
        busy_bad = 0;
        seen     = 1'b0;
        fin      = c0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (!busy) busy_bad++;
            if (done) begin
                seen = 1'b1;
                fin  = cyc;
            end else begin
                in_valid = poke && sa_rst_n;
                step();
            end
        end
        check_val({tag, " done seen"}, seen, 1'b1);
        if (tc == 0)   lat_exp = 1;
        else if (dead) lat_exp = 5 + c_to + 1;
        else           lat_exp = tc * (10 + lat) + 1;
        check_val({tag, " latency"}, fin - c0, lat_exp);
        in_valid = poke;
        step();
        in_valid = 1'b0;
        check_val({tag, " idle"}, {busy, done}, 2'b00);
        step(3);
        check_val({tag, " done cnt"}, done_cnt, 1);
        check_val({tag, " error"}, error, dead);
        check_val({tag, " busy"}, {busy_bad, busy}, 0);
        compare_writes(tag);
        sa_dead = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " ctrl"}, {busy, done, error, sa_rst_n, C_wr_en}, 5'b0);
        check_val({tag, " idx"}, {A_index, B_index, C_index}, 0);
        check_val({tag, " cdata"}, C_data_in, 0);
        check_val({tag, " ops"}, {lba0, lba1, lba2, lba3, lbb0, lbb1, lbb2, lbb3}, 0);
    endtask

    task automatic reset_mid(input bit in_store, input string tag);
        bit hit;
        sa_lat = 15;
        start_job(2, 16'($urandom), 16'($urandom), 16'($urandom));
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (in_store ? C_wr_en : sa_rst_n) hit = 1'b1;
            else step();
        end
        check_val({tag, " reached"}, hit, 1'b1);
        step(in_store ? 1 : 3);
        rst = 1'b1;
        act_idx.delete();
        act_dat.delete();
        step();
        rst = 1'b0;
        check_reset_state(tag);
        step(3);
        check_val({tag, " no wr"}, act_idx.size(), 0);
    endtask

    initial begin
        logic [15:0] ai, bi;
        for (int i = 0; i < 65536; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
        step(2);
        check_reset_state("por");
        rst = 1'b0;
        step();

        // Identity A against a known B.
        mem_a[0]  = 32'h01000000; mem_a[1]  = 32'h00010000;
        mem_a[2]  = 32'h00000100; mem_a[3]  = 32'h00000001;
        mem_b[8]  = 32'h01020304; mem_b[9]  = 32'h05060708;
        mem_b[10] = 32'h090A0B0C; mem_b[11] = 32'h0D0E0F10;
        run_job(1, 16'h0000, 16'h0008, 16'h0010, 13, 1'b0, 1'b0, "ident");
        check_val("ident C16", act_dat.size() > 0 ? act_dat[0] : '0,
                  128'h00000001_00000002_00000003_00000004);
        check_val("ident C19", act_dat.size() > 3 ? act_dat[3] : '0,
                  128'h0000000D_0000000E_0000000F_00000010);

        run_job(2, 16'h0000, 16'h0000, 16'h0020, int'($urandom_range(1, 20)), 1'b0, 1'b0, "two");

        ai = A_index;
        bi = B_index;
        run_job(0, 16'h1234, 16'h5678, 16'h9ABC, 5, 1'b0, 1'b0, "zero");
        check_val("zero idx hold", {A_index, B_index}, {ai, bi});

        run_job(2, 16'($urandom), 16'($urandom), 16'($urandom), 5, 1'b1, 1'b0, "tmo");
        check_val("tmo sticky", error, 1'b1);
        run_job(1, 16'($urandom), 16'($urandom), 16'($urandom), 9, 1'b0, 1'b0, "recover");

        run_job(2, 16'($urandom), 16'($urandom), 16'($urandom), 7, 1'b0, 1'b1, "poke");

        reset_mid(1'b0, "rst_run");
        run_job(1, 16'($urandom), 16'($urandom), 16'($urandom), 6, 1'b0, 1'b0, "after_run");
        reset_mid(1'b1, "rst_store");
        run_job(1, 16'($urandom), 16'($urandom), 16'($urandom), 6, 1'b0, 1'b0, "after_store");

        run_job(1, 16'hFFFD, 16'hFFFE, 16'hFFFE, 4, 1'b0, 1'b0, "wrap");

        for (int n = 0; n < 6; n++) begin
            run_job(int'($urandom_range(1, 4)), 16'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(1, 20)), 1'b0, 1'b0, $sformatf("rnd%0d", n));
        end

        sa_spur = 1'b1;
        step();
        sa_spur = 1'b0;
        step(2);
        check_val("spurious sa_done", {busy, sa_rst_n, C_wr_en, done}, 4'b0);

        check_val("sa_rst_n in store", bad_sarst, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sa_tile_sequencer.md
Name: sa_tile_sequencer

Overview:
Initiator-side controller for the 4x4 systolic_array.
- Fetches 4 A words and 4 B words per tile from the global buffers and presents them on the array's local_buffer_A*/B* inputs.
- Releases the array's sa_rst_n, waits for its done pulse, captures local_buffer_C0..C3 and writes them back to global buffer C.
- Repeats for tile_count consecutive tiles, then pulses done to the top-level host FSM.

Parameters:
ADDR_BITS, 16, global-buffer index width
DATA_BITS, 32, A/B word width (4 packed int8)
DATAC_BITS, 128, C word width (4 packed 32-bit results)
TIMEOUT_CYC, 32, max cycles in RUN awaiting sa_done before error

Ports:
clk  in  1  clock; every register updates on posedge
rst  in  1  synchronous reset, active-high
in_valid  in  1  start request; sampled only in IDLE
tile_count  in  8  number of tiles; latched on accepted start
a_base, b_base, c_base  in  ADDR_BITS each  base indices; latched on accepted start
busy  out  1  high from the cycle after start acceptance through the done cycle
done  out  1  one-cycle completion pulse
error  out  1  sticky timeout flag; cleared on next accepted start
A_index, B_index  out  ADDR_BITS  global buffer A/B read index
A_data_out, B_data_out  in  DATA_BITS  read data, valid 1 cycle after index
C_wr_en  out  1  global buffer C write strobe
C_index  out  ADDR_BITS  C write index
C_data_in  out  DATAC_BITS  C write data
sa_rst_n  out  1  array run enable; 0 holds the array in load state
local_buffer_A0..A3, local_buffer_B0..B3  out  DATA_BITS  registered operand words to array
local_buffer_C0..C3  in  DATAC_BITS  array results
sa_done  in  1  array completion pulse

Behaviour:
- Reset (rst=1 at posedge, any state): go to IDLE.
  - busy=0, done=0, error=0, sa_rst_n=0, C_wr_en=0.
  - All indices, operand registers and C_data_in = 0.
  - No global-buffer write may occur in the reset cycle or the cycle after it.
- States: IDLE, LOAD, RUN, STORE, NEXT, FIN.
- IDLE, on in_valid=1:
  - Latch tile_count and the three bases; clear error; tile counter t=0.
  - tile_count=0 -> FIN directly, with no buffer access.
  - Otherwise -> LOAD.
- LOAD (5 cycles, k=0..4):
  - For k<4, drive A_index=a_base+4t+k and B_index=b_base+4t+k.
  - At cycle k (k>=1), register A_data_out into local_buffer_A(k-1) and B_data_out into local_buffer_B(k-1).
  - sa_rst_n stays 0 throughout. Then -> RUN.
- RUN:
  - sa_rst_n=1. Operand registers are held constant.
  - Cycle counter starts at 0 and increments each RUN cycle.
  - On sa_done=1: capture local_buffer_C0..C3 into an internal 4x128 buffer, drive sa_rst_n=0 at that same edge (the array must not restart), -> STORE.
  - If the counter reaches TIMEOUT_CYC without sa_done: set error, sa_rst_n=0, -> FIN. Remaining tiles are abandoned.
- STORE (4 cycles, r=0..3): C_wr_en=1, C_index=c_base+4t+r, C_data_in=captured row r. Then -> NEXT.
- NEXT (1 cycle): t=t+1. If t==tile_count -> FIN, else -> LOAD.
- FIN: done=1 for exactly one cycle, busy=1 in that cycle; -> IDLE. busy=0 in the following cycle.
- Index arithmetic is modulo 2^ADDR_BITS; wrap-around is silent.
- in_valid is ignored in every state except IDLE. in_valid in the FIN cycle is also ignored.
- sa_done arriving outside RUN is ignored.
- Latency per tile = 5 (LOAD) + T_sa + 4 (STORE) + 1 (NEXT), where T_sa is cycles from sa_rst_n rise to sa_done (about 13 for systolic_array). Add +1 for FIN.
- Operand words are passed unmodified: byte lanes are not reordered.

Decomposition:
- Shared package holds: state encoding constants, TIMEOUT_CYC default, and the LOAD/STORE row count (4).
- One sub-module: sa_result_capture, the 4x128 capture register with load enable and row-select read port feeding C_data_in.

Test Plan:
- Single tile, a_base=0, b_base=8, c_base=16.
  - A = identity words 0x01000000, 0x00010000, 0x00000100, 0x00000001; B = 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10; real systolic_array attached.
  - Required: C[16] = 0x00000001_00000002_00000003_00000004, C[19] = 0x0000000D_0000000E_0000000F_00000010.
  - done pulses once; error=0.
- tile_count=2 with bases 0/0/0x20 -> reads at indices 0..7, writes at 0x20..0x27. sa_rst_n drops to 0 at each sa_done edge and stays 0 in STORE.
- tile_count=0 -> done pulse on the second cycle after start; no C_wr_en; A_index/B_index never change.
- sa_done tied 0 -> error=1 and a done pulse 32 RUN cycles after sa_rst_n rise. The next start with a responsive array clears error.
- in_valid asserted during RUN and during FIN -> ignored: tile count and bases unchanged, single done.
- rst asserted mid-RUN and mid-STORE -> next cycle all outputs at reset values, no further C_wr_en. A fresh start then completes correctly.
- c_base=0xFFFE -> C writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
